// File: rtl/prescaled_updown_counter_if.sv
// Control and status bundle for the prescaled up/down counter.
// The master drives the controls and the slave returns the count with its tick/tc pulses.
interface prescaled_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tick;
    logic             tc;

    modport master (output en, dir, load, load_val, input q, tick, tc);
    modport slave  (input en, dir, load, load_val, output q, tick, tc);
endinterface

// File: rtl/prescaled_updown_counter.sv
// Prescaled up/down counter: the clock is divided down to TICK_HZ, and each tick steps q (wrap or saturate).
// Latency: the first step comes DIV enabled cycles after presc=0, then one step every DIV cycles; there is no backpressure.
module prescaled_updown_counter #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 1,
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 2**WIDTH-1,
    parameter int WRAP      = 1,
    parameter int RESET_VAL = 0
) (
    input  logic                         clk_100MHz,
    input  logic                         rst_n,
    prescaled_updown_counter_if.slave    bus
);
    localparam int               DIV        = CLK_HZ / TICK_HZ;
    localparam int               PW         = $clog2(DIV);
    localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV-1);
    localparam logic [WIDTH-1:0] MAX_Q      = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] RST_Q      = WIDTH'(RESET_VAL);

    logic [PW-1:0]    r_presc;
    logic [WIDTH-1:0] r_q;
    logic             r_tick;
    logic             r_tc;

    logic [WIDTH-1:0] w_q_step;
    logic [WIDTH-1:0] w_q_load;
    logic             w_at_limit;

    // A step taken from the terminal value flags tc, whether it wraps or saturates.
    always_comb begin
        w_q_step   = r_q;
        w_at_limit = 1'b0;
        if (bus.dir) begin
            if (r_q == MAX_Q) begin
                w_at_limit = 1'b1;
                w_q_step   = (WRAP != 0) ? '0 : MAX_Q;
            end else begin
                w_q_step   = r_q + 1'b1;
            end
        end else begin
            if (r_q == '0) begin
                w_at_limit = 1'b1;
                w_q_step   = (WRAP != 0) ? MAX_Q : '0;
            end else begin
                w_q_step   = r_q - 1'b1;
            end
        end
    end

    assign w_q_load = (bus.load_val > MAX_Q) ? MAX_Q : bus.load_val;

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_q     <= RST_Q;
            r_tick  <= 1'b0;
            r_tc    <= 1'b0;
        end else if (bus.load) begin
            r_presc <= '0;
            r_q     <= w_q_load;
            r_tick  <= 1'b0;
            r_tc    <= 1'b0;
        end else if (bus.en) begin
            if (r_presc == PRESC_LAST) begin
                r_presc <= '0;
                r_q     <= w_q_step;
                r_tick  <= 1'b1;
                r_tc    <= w_at_limit;
            end else begin
                r_presc <= r_presc + 1'b1;
                r_tick  <= 1'b0;
                r_tc    <= 1'b0;
            end
        end else begin
            r_tick  <= 1'b0;
            r_tc    <= 1'b0;
        end
    end

    assign bus.q    = r_q;
    assign bus.tick = r_tick;
    assign bus.tc   = r_tc;
endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Directed bench: two counters at DIV=10, MAX_COUNT=9, one wrapping and one saturating.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_prescaled_updown_counter;
    logic clk_100MHz;
    logic rst_n;
    int   n_vec;
    int   n_err;

    prescaled_updown_counter_if #(.WIDTH(4)) m_if ();
    prescaled_updown_counter_if #(.WIDTH(4)) s_if ();

    prescaled_updown_counter #(
        .CLK_HZ(100), .TICK_HZ(10), .WIDTH(4), .MAX_COUNT(9), .WRAP(1), .RESET_VAL(0)
    ) u_wrap (
        .clk_100MHz(clk_100MHz), .rst_n(rst_n), .bus(m_if.slave)
    );

    prescaled_updown_counter #(
        .CLK_HZ(100), .TICK_HZ(10), .WIDTH(4), .MAX_COUNT(9), .WRAP(0), .RESET_VAL(0)
    ) u_sat (
        .clk_100MHz(clk_100MHz), .rst_n(rst_n), .bus(s_if.slave)
    );

    initial begin
        clk_100MHz = 1'b0;
        forever #5 clk_100MHz = ~clk_100MHz;
    end

    task automatic test_reset();
        rst_n = 1'b0;
        m_if.en = 1'b0; m_if.dir = 1'b1; m_if.load = 1'b0; m_if.load_val = 4'd0;
        s_if.en = 1'b0; s_if.dir = 1'b1; s_if.load = 1'b0; s_if.load_val = 4'd0;
        repeat (10) @(negedge clk_100MHz);
        n_vec++;
        if ({m_if.q, m_if.tick, m_if.tc} !== 6'b0000_00) begin
            n_err++;
            $display("FAIL reset_held: got q/tick/tc=%b want %b", {m_if.q, m_if.tick, m_if.tc}, 6'b0);
        end
        rst_n = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk_100MHz);
            n_vec++;
            if ({m_if.q, m_if.tick, m_if.tc, s_if.q, s_if.tick, s_if.tc} !== 12'b0) begin
                n_err++;
                $display("FAIL reset_idle cyc %0d: got wrap=%b sat=%b want 0", c,
                         {m_if.q, m_if.tick, m_if.tc}, {s_if.q, s_if.tick, s_if.tc});
            end
        end
    endtask

    task automatic test_up_wrap();
        logic [3:0] seq [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
        logic       tcs [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [3:0] prev = 4'd0;
        logic [5:0] exp;
        m_if.en = 1'b1; m_if.dir = 1'b1;
        for (int k = 0; k < 10; k++) begin
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk_100MHz);
                exp = (c < 10) ? {prev, 2'b00} : {seq[k], 1'b1, tcs[k]};
                n_vec++;
                if ({m_if.q, m_if.tick, m_if.tc} !== exp) begin
                    n_err++;
                    $display("FAIL up_wrap step %0d cyc %0d: got q/tick/tc=%b want %b", k, c,
                             {m_if.q, m_if.tick, m_if.tc}, exp);
                end
            end
            prev = seq[k];
        end
        m_if.en = 1'b0;
    endtask

    task automatic test_down_wrap();
        logic [3:0] seq [3] = '{4'd1, 4'd0, 4'd9};
        logic       tcs [3] = '{1'b0, 1'b0, 1'b1};
        logic [3:0] prev = 4'd2;
        logic [5:0] exp;
        m_if.load = 1'b1; m_if.load_val = 4'd2; m_if.dir = 1'b0; m_if.en = 1'b1;
        @(negedge clk_100MHz);
        n_vec++;
        if ({m_if.q, m_if.tick, m_if.tc} !== {4'd2, 2'b00}) begin
            n_err++;
            $display("FAIL down_load: got q/tick/tc=%b want %b", {m_if.q, m_if.tick, m_if.tc}, {4'd2, 2'b00});
        end
        m_if.load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk_100MHz);
                exp = (c < 10) ? {prev, 2'b00} : {seq[k], 1'b1, tcs[k]};
                n_vec++;
                if ({m_if.q, m_if.tick, m_if.tc} !== exp) begin
                    n_err++;
                    $display("FAIL down_wrap step %0d cyc %0d: got q/tick/tc=%b want %b", k, c,
                             {m_if.q, m_if.tick, m_if.tc}, exp);
                end
            end
            prev = seq[k];
        end
        m_if.en = 1'b0;
    endtask

    task automatic test_saturate();
        logic       tcs [3] = '{1'b0, 1'b1, 1'b1};
        logic [3:0] prev = 4'd8;
        logic [5:0] exp;
        s_if.load = 1'b1; s_if.load_val = 4'd8; s_if.dir = 1'b1; s_if.en = 1'b1;
        @(negedge clk_100MHz);
        n_vec++;
        if ({s_if.q, s_if.tick, s_if.tc} !== {4'd8, 2'b00}) begin
            n_err++;
            $display("FAIL sat_load: got q/tick/tc=%b want %b", {s_if.q, s_if.tick, s_if.tc}, {4'd8, 2'b00});
        end
        s_if.load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk_100MHz);
                exp = (c < 10) ? {prev, 2'b00} : {4'd9, 1'b1, tcs[k]};
                n_vec++;
                if ({s_if.q, s_if.tick, s_if.tc} !== exp) begin
                    n_err++;
                    $display("FAIL saturate step %0d cyc %0d: got q/tick/tc=%b want %b", k, c,
                             {s_if.q, s_if.tick, s_if.tc}, exp);
                end
            end
            prev = 4'd9;
        end
        s_if.en = 1'b0;
    endtask

    task automatic test_load_enable();
        logic [5:0] exp;
        m_if.load = 1'b1; m_if.load_val = 4'd0; m_if.en = 1'b0; m_if.dir = 1'b1;
        @(negedge clk_100MHz);
        n_vec++;
        if (m_if.q !== 4'd0) begin
            n_err++;
            $display("FAIL load_zero: got q=%0d want 0", m_if.q);
        end
        m_if.load_val = 4'd15;
        @(negedge clk_100MHz);
        n_vec++;
        if ({m_if.q, m_if.tick, m_if.tc} !== {4'd9, 2'b00}) begin
            n_err++;
            $display("FAIL load_clamp: got q/tick/tc=%b want %b", {m_if.q, m_if.tick, m_if.tc}, {4'd9, 2'b00});
        end
        m_if.load = 1'b0; m_if.en = 1'b1;
        // 4 enabled, 7 frozen, then 6 enabled cycles to the step (presc 4 -> 9 -> step).
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk_100MHz);
            exp = (c == 17) ? {4'd0, 2'b11} : {4'd9, 2'b00};
            n_vec++;
            if ({m_if.q, m_if.tick, m_if.tc} !== exp) begin
                n_err++;
                $display("FAIL en_pause cyc %0d: got q/tick/tc=%b want %b", c, {m_if.q, m_if.tick, m_if.tc}, exp);
            end
            m_if.en = (c >= 4 && c < 11) ? 1'b0 : 1'b1;
        end
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk_100MHz);
            n_vec++;
            if ({m_if.q, m_if.tick, m_if.tc} !== {4'd0, 2'b00}) begin
                n_err++;
                $display("FAIL pre_tick cyc %0d: got q/tick/tc=%b want %b", c, {m_if.q, m_if.tick, m_if.tc}, {4'd0, 2'b00});
            end
        end
        m_if.load = 1'b1; m_if.load_val = 4'd6;
        @(negedge clk_100MHz);
        n_vec++;
        if ({m_if.q, m_if.tick, m_if.tc} !== {4'd6, 2'b00}) begin
            n_err++;
            $display("FAIL load_on_tick: got q/tick/tc=%b want %b", {m_if.q, m_if.tick, m_if.tc}, {4'd6, 2'b00});
        end
        m_if.load = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk_100MHz);
            exp = (c == 10) ? {4'd7, 2'b10} : {4'd6, 2'b00};
            n_vec++;
            if ({m_if.q, m_if.tick, m_if.tc} !== exp) begin
                n_err++;
                $display("FAIL after_load cyc %0d: got q/tick/tc=%b want %b", c, {m_if.q, m_if.tick, m_if.tc}, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [5:0] exp;
        m_if.load = 1'b1; m_if.load_val = 4'd4; m_if.en = 1'b1; m_if.dir = 1'b1;
        @(negedge clk_100MHz);
        m_if.load = 1'b0;
        // q=4 presc=0 -> step to 5 at cycle 10 -> presc=7 at cycle 17.
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk_100MHz);
            exp = (c < 10) ? {4'd4, 2'b00} : (c == 10) ? {4'd5, 2'b10} : {4'd5, 2'b00};
            n_vec++;
            if ({m_if.q, m_if.tick, m_if.tc} !== exp) begin
                n_err++;
                $display("FAIL pre_reset cyc %0d: got q/tick/tc=%b want %b", c, {m_if.q, m_if.tick, m_if.tc}, exp);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({m_if.q, m_if.tick, m_if.tc} !== 6'b0) begin
            n_err++;
            $display("FAIL async_clear: got q/tick/tc=%b want %b", {m_if.q, m_if.tick, m_if.tc}, 6'b0);
        end
        repeat (2) @(negedge clk_100MHz);
        rst_n = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk_100MHz);
            exp = (c == 10) ? {4'd1, 2'b10} : {4'd0, 2'b00};
            n_vec++;
            if ({m_if.q, m_if.tick, m_if.tc} !== exp) begin
                n_err++;
                $display("FAIL post_reset cyc %0d: got q/tick/tc=%b want %b", c, {m_if.q, m_if.tick, m_if.tc}, exp);
            end
        end
        m_if.en = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_saturate();
        test_load_enable();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
